// File: rtl/tt_capture_pkg.sv
// Shared definitions for the truth-table capture block: FSM state encoding,
// default widths and the table-depth helper.
package tt_capture_pkg;

    localparam int TT_IN_W       = 9;
    localparam int TT_OUT_W      = 4;
    localparam int TT_SETTLE_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DUMP  = 2'd2,
        ST_FIN   = 2'd3
    } tt_state_t;

    // Number of table entries for an in_w-bit input vector.
    function automatic int tt_depth(input int in_w);
        return 1 << in_w;
    endfunction

endpackage

// File: rtl/tt_capture_ram.sv
// Simple dual-port table storage: one synchronous write port, one synchronous
// read port with a one-cycle latency. The read register holds its value while
// rd_en is low, so the captured entry stays stable across stalls downstream.
// Only the read register is reset; the array contents are never cleared.
module tt_capture_ram
    import tt_capture_pkg::*;
#(
    parameter int ADDR_W = TT_IN_W,
    parameter int DATA_W = TT_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = tt_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the sampled DUT response.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, updated only on a read cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/truth_table_capture.sv
// Truth-table writer. Sweeps every IN_W-bit vector out on o_x, holds each for
// SETTLE_CYC cycles, captures i_y on the last cycle into the table RAM, then
// streams the table out one entry per address in ascending order.
//
// Stream handshake: a beat transfers on a rising clk edge where o_valid and
// i_ready are both high. Once o_valid is raised, o_valid, o_addr and o_data
// stay unchanged until that transfer; o_valid never depends on i_ready.
//
// Optional build macro TT_CAPTURE_CMP_EN adds a reference response input
// (i_y_ref) and mismatch statistics gathered during the sweep.
module truth_table_capture
    import tt_capture_pkg::*;
#(
    parameter int IN_W       = TT_IN_W,
    parameter int OUT_W      = TT_OUT_W,
    parameter int SETTLE_CYC = TT_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  o_x,
    input  logic [OUT_W-1:0] i_y,
    output logic             busy,
    output logic             done,
    output logic             o_valid,
    output logic [IN_W-1:0]  o_addr,
    output logic [OUT_W-1:0] o_data,
    input  logic             i_ready,
`ifdef TT_CAPTURE_CMP_EN
    input  logic [OUT_W-1:0] i_y_ref,
    output logic [IN_W:0]    mism_cnt,
    output logic [IN_W-1:0]  first_mism_addr,
    output logic             mism_seen,
`endif
    output tt_state_t        fsm_state
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [IN_W-1:0]  ADDR_LAST   = '1;

    tt_state_t         state;
    tt_state_t         state_nxt;
    logic [IN_W-1:0]   addr;
    logic [SET_W-1:0]  settle;
    logic              sample_now;
    logic              beat_accept;
    logic              rd_en;
    logic [OUT_W-1:0]  rd_data;

    // The vector has settled long enough on the last hold cycle.
    assign sample_now  = (state == ST_SWEEP) && (settle == SETTLE_LAST);
    // A stream beat transfers this cycle.
    assign beat_accept = (state == ST_DUMP) && o_valid && i_ready;
    assign fsm_state   = state;
    assign o_data      = rd_data;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_SWEEP;
            ST_SWEEP: if (sample_now && (addr == ADDR_LAST)) state_nxt = ST_DUMP;
            ST_DUMP:  if (beat_accept && (o_addr == ADDR_LAST)) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; a DUMP cycle without a pending beat is a read cycle.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        o_x   = '0;
        rd_en = 1'b0;
        unique case (state)
            ST_IDLE:  ;
            ST_SWEEP: begin
                busy = 1'b1;
                o_x  = addr;
            end
            ST_DUMP: begin
                busy  = 1'b1;
                rd_en = !o_valid;
            end
            ST_FIN:   done = 1'b1;
            default:  ;
        endcase
    end

    // Address and settle counters; terminal compare comes before any increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            settle <= '0;
        end else begin
            unique case (state)
                ST_SWEEP: begin
                    if (sample_now) begin
                        settle <= '0;
                        addr   <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (beat_accept) begin
                        addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
                    end
                end
                default: begin
                    addr   <= '0;
                    settle <= '0;
                end
            endcase
        end
    end

    // Stream beat register: raise valid after each read cycle, drop it on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_addr  <= '0;
        end else if (state == ST_DUMP) begin
            if (!o_valid) begin
                o_valid <= 1'b1;
                o_addr  <= addr;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end else begin
            o_valid <= 1'b0;
        end
    end

    tt_capture_ram #(
        .ADDR_W (IN_W),
        .DATA_W (OUT_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sample_now),
        .wr_addr (addr),
        .wr_data (i_y),
        .rd_en   (rd_en),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

`ifdef TT_CAPTURE_CMP_EN
    // Mismatch statistics against the reference response, cleared when a sweep is accepted.
    always_ff @(posedge clk) begin
        if (rst || ((state == ST_IDLE) && start)) begin
            mism_cnt        <= '0;
            first_mism_addr <= '0;
            mism_seen       <= 1'b0;
        end else if (sample_now && (i_y != i_y_ref)) begin
            if (mism_cnt != '1) begin
                mism_cnt <= mism_cnt + 1'b1;
            end
            if (!mism_seen) begin
                first_mism_addr <= addr;
                mism_seen       <= 1'b1;
            end
        end
    end
`endif

endmodule
